// File: rtl/riscv_icache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped L1 instruction cache.
package riscv_icache_pkg;

   localparam int DATA_WIDTH  = 128;
   localparam int CACHE_SIZE  = 4 * (2 ** 10);
   localparam int MEM_SIZE    = 64 * (2 ** 10);
   localparam int DATAPBLOCK  = 16;
   localparam int CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK;
   localparam int ADDR        = $clog2(MEM_SIZE);
   localparam int BYTE_OFF    = $clog2(DATAPBLOCK);
   localparam int INDEX       = $clog2(CACHE_DEPTH);
   localparam int TAG         = ADDR - BYTE_OFF - INDEX;
   localparam int S_ADDR      = ADDR - BYTE_OFF;

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      UPDATE
   } state_t;

endpackage

// File: rtl/riscv_icache_tag.sv
// Tag and valid storage: combinational lookup, synchronous fill,
// single-cycle invalidate of every line.
module riscv_icache_tag
   import riscv_icache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [INDEX-1:0] rd_idx,
   input  logic [TAG-1:0]   rd_tag,
   input  logic             wr_en,
   input  logic [INDEX-1:0] wr_idx,
   input  logic [TAG-1:0]   wr_tag,
   input  logic             clr,
   output logic             hit
);

   logic [CACHE_DEPTH-1:0] valid;
   logic [TAG-1:0]         tag_arr [CACHE_DEPTH];

   // Invalidate wins over a fill landing on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (clr) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_arr[wr_idx] <= wr_tag;
      end
   end

   assign hit = valid[rd_idx] & (tag_arr[rd_idx] == rd_tag);

endmodule

// File: rtl/riscv_icache_ctrl.sv
// Direct-mapped L1 I-cache controller: same-cycle hits, one-block
// refill over the RAM rden/ready handshake, then a replayed lookup.
module riscv_icache_ctrl
   import riscv_icache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_rden,
   input  logic [ADDR-1:0]       cpu_addr,
   input  logic                  flush,
   output logic [31:0]           instr,
   output logic                  stall,
   output logic                  mem_rden,
   output logic [S_ADDR-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_ready
);

   state_t state;
   state_t state_nxt;

   logic                  flush_pend;
   logic                  hit;
   logic                  tag_we;
   logic                  tag_clr;
   logic                  start;
   logic [TAG-1:0]        tag;
   logic [INDEX-1:0]      idx;
   logic [1:0]            word;
   logic [INDEX-1:0]      idx_l;
   logic [TAG-1:0]        tag_l;
   logic [DATA_WIDTH-1:0] line;
   logic                  unused_bits;

   logic [DATA_WIDTH-1:0] data_arr [CACHE_DEPTH];

   assign tag         = cpu_addr[ADDR-1 -: TAG];
   assign idx         = cpu_addr[BYTE_OFF +: INDEX];
   assign word        = cpu_addr[3:2];
   assign unused_bits = ^cpu_addr[1:0];

   // The latched block address already carries the fill tag and index.
   assign idx_l = mem_addr[INDEX-1:0];
   assign tag_l = mem_addr[S_ADDR-1 -: TAG];

   riscv_icache_tag u_tag (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (idx),
      .rd_tag (tag),
      .wr_en  (tag_we),
      .wr_idx (idx_l),
      .wr_tag (tag_l),
      .clr    (tag_clr),
      .hit    (hit)
   );

   always_comb begin
      state_nxt = state;
      tag_we    = 1'b0;
      tag_clr   = 1'b0;
      start     = 1'b0;
      unique case (state)
         IDLE: begin
            if (flush) begin
               tag_clr = 1'b1;
            end else if (cpu_rden && !hit) begin
               start     = 1'b1;
               state_nxt = REFILL;
            end
         end
         REFILL: begin
            if (mem_ready) begin
               tag_we    = 1'b1;
               state_nxt = UPDATE;
            end
         end
         UPDATE: begin
            state_nxt = IDLE;
            tag_clr   = flush_pend | flush;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         flush_pend <= 1'b0;
         mem_rden   <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            mem_rden <= 1'b1;
            mem_addr <= cpu_addr[ADDR-1:BYTE_OFF];
         end else if (tag_we) begin
            mem_rden <= 1'b0;
         end
         if (state == UPDATE) begin
            flush_pend <= 1'b0;
         end else if (state == REFILL && flush) begin
            flush_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         data_arr[idx_l] <= mem_data_in;
      end
   end

   assign line  = data_arr[idx];
   assign stall = (state != IDLE) | (cpu_rden & ~hit);
   assign instr = (cpu_rden && !stall) ? line[{word, 5'b00000} +: 32] : 32'h0;

endmodule
